// File: rtl/rs_dispatch_queue_pkg.sv
// rtl/rs_dispatch_queue_pkg.sv - shared class encodings, port indices and opcode constants
package rs_dispatch_queue_pkg;

    typedef enum logic [2:0] {
        CLS_ALU = 3'd0,
        CLS_MUL = 3'd1,
        CLS_DIV = 3'd2,
        CLS_LS  = 3'd3,
        CLS_BR  = 3'd4
    } cls_e;

    localparam int NUM_PORTS = 6;
    localparam int PORT_PASS = 0;
    localparam int PORT_ALU  = 1;
    localparam int PORT_MUL  = 2;
    localparam int PORT_DIV  = 3;
    localparam int PORT_LS   = 4;
    localparam int PORT_BR   = 5;

    localparam logic [6:0] OP_NONE   = 7'b0000000;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_REM    = 3'b110;

    // ALU-class work goes to PASS only when both operands are already present
    function automatic logic [NUM_PORTS-1:0] port_onehot(cls_e cls, logic [1:0] ops, logic pass_en);
        logic [NUM_PORTS-1:0] v;
        v = '0;
        case (cls)
            CLS_BR:  v[PORT_BR]  = 1'b1;
            CLS_LS:  v[PORT_LS]  = 1'b1;
            CLS_MUL: v[PORT_MUL] = 1'b1;
            CLS_DIV: v[PORT_DIV] = 1'b1;
            default: begin
                if (pass_en && (ops == 2'b11)) v[PORT_PASS] = 1'b1;
                else                           v[PORT_ALU]  = 1'b1;
            end
        endcase
        return v;
    endfunction

endpackage

// File: rtl/rs_dispatch_queue_if.sv
// rtl/rs_dispatch_queue_if.sv - enqueue, wakeup and dispatch bundle with master/slave views
interface rs_dispatch_queue_if #(
    parameter int DEPTH = 4,
    parameter int PHY_W = 8,
    parameter int XLEN  = 32
);
    logic                       in_valid;
    logic                       in_ready;
    logic [6:0]                 in_opcode;
    logic [2:0]                 in_func3;
    logic [6:0]                 in_funct7;
    logic [XLEN-1:0]            in_pc;
    logic [XLEN-1:0]            in_immediate;
    logic [XLEN-1:0]            in_inst_num;
    logic [XLEN-1:0]            in_op1_data;
    logic [XLEN-1:0]            in_op2_data;
    logic [PHY_W-1:0]           in_rd_phy;
    logic [PHY_W-1:0]           in_op1_phy;
    logic [PHY_W-1:0]           in_op2_phy;
    logic [1:0]                 in_valid_ops;
    logic [9:0]                 in_ctrl;
    logic                       in_branch;
    logic                       in_taken;
    logic                       in_hit;

    logic                       cdb_valid;
    logic [PHY_W-1:0]           cdb_phy;
    logic [XLEN-1:0]            cdb_data;

    logic [5:0]                 out_valid;
    logic [5:0]                 out_ready;
    logic [6:0]                 out_opcode;
    logic [2:0]                 out_func3;
    logic [6:0]                 out_funct7;
    logic [XLEN-1:0]            out_pc;
    logic [XLEN-1:0]            out_immediate;
    logic [XLEN-1:0]            out_inst_num;
    logic [XLEN-1:0]            out_op1_data;
    logic [XLEN-1:0]            out_op2_data;
    logic [PHY_W-1:0]           out_rd_phy;
    logic [PHY_W-1:0]           out_op1_phy;
    logic [PHY_W-1:0]           out_op2_phy;
    logic [1:0]                 out_valid_ops;
    logic [9:0]                 out_ctrl;
    logic                       out_branch;
    logic                       out_taken;
    logic                       out_hit;

    logic [$clog2(DEPTH):0]     count;

    modport slave (
        input  in_valid, in_opcode, in_func3, in_funct7, in_pc, in_immediate, in_inst_num,
               in_op1_data, in_op2_data, in_rd_phy, in_op1_phy, in_op2_phy, in_valid_ops,
               in_ctrl, in_branch, in_taken, in_hit, cdb_valid, cdb_phy, cdb_data, out_ready,
        output in_ready, out_valid, out_opcode, out_func3, out_funct7, out_pc, out_immediate,
               out_inst_num, out_op1_data, out_op2_data, out_rd_phy, out_op1_phy, out_op2_phy,
               out_valid_ops, out_ctrl, out_branch, out_taken, out_hit, count
    );

    modport master (
        output in_valid, in_opcode, in_func3, in_funct7, in_pc, in_immediate, in_inst_num,
               in_op1_data, in_op2_data, in_rd_phy, in_op1_phy, in_op2_phy, in_valid_ops,
               in_ctrl, in_branch, in_taken, in_hit, cdb_valid, cdb_phy, cdb_data, out_ready,
        input  in_ready, out_valid, out_opcode, out_func3, out_funct7, out_pc, out_immediate,
               out_inst_num, out_op1_data, out_op2_data, out_rd_phy, out_op1_phy, out_op2_phy,
               out_valid_ops, out_ctrl, out_branch, out_taken, out_hit, count
    );

endinterface

// File: rtl/rs_dispatch_queue_classify.sv
// rtl/rs_dispatch_queue_classify.sv - combinational decode of an instruction into its issue class
module dispatch_classify
    import rs_dispatch_queue_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] func3_i,
    input  logic [6:0] funct7_i,
    output cls_e       cls_o
);

    // Branch/jump and memory opcodes first; only M-extension MUL/DIV/REM leave the ALU class
    always_comb begin
        cls_o = CLS_ALU;
        if (opcode_i == OP_JAL || opcode_i == OP_JALR || opcode_i == OP_BRANCH) begin
            cls_o = CLS_BR;
        end else if (opcode_i == OP_LOAD || opcode_i == OP_STORE) begin
            cls_o = CLS_LS;
        end else if (opcode_i == OP_REG && funct7_i == F7_MULDIV) begin
            if (func3_i == F3_MUL)                          cls_o = CLS_MUL;
            else if (func3_i == F3_DIV || func3_i == F3_REM) cls_o = CLS_DIV;
        end
    end

endmodule

// File: rtl/rs_dispatch_queue.sv
// rtl/rs_dispatch_queue.sv - in-order reservation queue with CDB wakeup and one-hot port dispatch
module rs_dispatch_queue
    import rs_dispatch_queue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int PHY_W   = 8,
    parameter int XLEN    = 32,
    parameter int PASS_EN = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    rs_dispatch_queue_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        cls_e             cls;
        logic [6:0]       opcode;
        logic [2:0]       func3;
        logic [6:0]       funct7;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  inst_num;
        logic [XLEN-1:0]  op1_data;
        logic [XLEN-1:0]  op2_data;
        logic [PHY_W-1:0] rd_phy;
        logic [PHY_W-1:0] op1_phy;
        logic [PHY_W-1:0] op2_phy;
        logic [1:0]       valid_ops;
        logic [9:0]       ctrl;
        logic             branch;
        logic             taken;
        logic             hit;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    cls_e              in_cls;
    entry_t            in_entry;
    entry_t            head;
    logic              full, empty, enq, write, deq;
    logic [5:0]        port_sel;

    dispatch_classify u_classify (
        .opcode_i (bus.in_opcode),
        .func3_i  (bus.in_func3),
        .funct7_i (bus.in_funct7),
        .cls_o    (in_cls)
    );

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign enq   = bus.in_valid && !full && !flush;
    // A zero opcode completes the handshake but never takes a slot
    assign write = enq && (bus.in_opcode != OP_NONE);
    assign head  = mem_q[rd_ptr_q];
    assign deq   = |(bus.out_valid & bus.out_ready);

    // Incoming entry, including a same-cycle CDB match on either source tag
    always_comb begin
        in_entry           = '0;
        in_entry.cls       = in_cls;
        in_entry.opcode    = bus.in_opcode;
        in_entry.func3     = bus.in_func3;
        in_entry.funct7    = bus.in_funct7;
        in_entry.pc        = bus.in_pc;
        in_entry.imm       = bus.in_immediate;
        in_entry.inst_num  = bus.in_inst_num;
        in_entry.op1_data  = bus.in_op1_data;
        in_entry.op2_data  = bus.in_op2_data;
        in_entry.rd_phy    = bus.in_rd_phy;
        in_entry.op1_phy   = bus.in_op1_phy;
        in_entry.op2_phy   = bus.in_op2_phy;
        in_entry.valid_ops = bus.in_valid_ops;
        in_entry.ctrl      = bus.in_ctrl;
        in_entry.branch    = bus.in_branch;
        in_entry.taken     = bus.in_taken;
        in_entry.hit       = bus.in_hit;
        if (bus.cdb_valid && bus.in_op1_phy == bus.cdb_phy) begin
            in_entry.valid_ops[1] = 1'b1;
            in_entry.op1_data     = bus.cdb_data;
        end
        if (bus.cdb_valid && bus.in_op2_phy == bus.cdb_phy) begin
            in_entry.valid_ops[0] = 1'b1;
            in_entry.op2_data     = bus.cdb_data;
        end
    end

    // Next pointers and occupancy; flush wins over any concurrent enqueue or dequeue
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(write);
        rd_ptr_d = rd_ptr_q + PTR_W'(deq);
        count_d  = count_q + CNT_W'(write) - CNT_W'(deq);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Control state: pointers, occupancy and per-entry valid bits
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (flush) begin
                vld_q <= '0;
            end else begin
                if (deq)   vld_q[rd_ptr_q] <= 1'b0;
                if (write) vld_q[wr_ptr_q] <= 1'b1;
            end
        end
    end

    // Entry payload: CDB wakeup of resident entries, then capture of the new entry
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && bus.cdb_valid) begin
                if (mem_q[i].op1_phy == bus.cdb_phy) begin
                    mem_q[i].valid_ops[1] <= 1'b1;
                    mem_q[i].op1_data     <= bus.cdb_data;
                end
                if (mem_q[i].op2_phy == bus.cdb_phy) begin
                    mem_q[i].valid_ops[0] <= 1'b1;
                    mem_q[i].op2_data     <= bus.cdb_data;
                end
            end
        end
        if (write && !reset) mem_q[wr_ptr_q] <= in_entry;
    end

    // Port choice for the head, derived purely from registered entry state
    always_comb begin
        port_sel = '0;
        if (!empty) port_sel = port_onehot(head.cls, head.valid_ops, PASS_EN != 0);
    end

    assign bus.in_ready      = !full;
    assign bus.count         = count_q;
    assign bus.out_valid     = port_sel;
    assign bus.out_opcode    = empty ? '0 : head.opcode;
    assign bus.out_func3     = empty ? '0 : head.func3;
    assign bus.out_funct7    = empty ? '0 : head.funct7;
    assign bus.out_pc        = empty ? '0 : head.pc;
    assign bus.out_immediate = empty ? '0 : head.imm;
    assign bus.out_inst_num  = empty ? '0 : head.inst_num;
    assign bus.out_op1_data  = empty ? '0 : head.op1_data;
    assign bus.out_op2_data  = empty ? '0 : head.op2_data;
    assign bus.out_rd_phy    = empty ? '0 : head.rd_phy;
    assign bus.out_op1_phy   = empty ? '0 : head.op1_phy;
    assign bus.out_op2_phy   = empty ? '0 : head.op2_phy;
    assign bus.out_valid_ops = empty ? '0 : head.valid_ops;
    assign bus.out_ctrl      = empty ? '0 : head.ctrl;
    assign bus.out_branch    = empty ? 1'b0 : head.branch;
    assign bus.out_taken     = empty ? 1'b0 : head.taken;
    assign bus.out_hit       = empty ? 1'b0 : head.hit;

endmodule

// File: tb/tb_rs_dispatch_queue.sv
// tb/tb_rs_dispatch_queue.sv - table and scenario bench for rs_dispatch_queue
module tb_rs_dispatch_queue;

    localparam int DEPTH = 4;
    localparam int PHY_W = 8;
    localparam int XLEN  = 32;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    always #5 clk = ~clk;

    rs_dispatch_queue_if #(.DEPTH(DEPTH), .PHY_W(PHY_W), .XLEN(XLEN)) bus ();

    rs_dispatch_queue #(.DEPTH(DEPTH), .PHY_W(PHY_W), .XLEN(XLEN), .PASS_EN(1)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [6:0] opcode;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [1:0] ops;
        logic [5:0] exp_port;
    } vec_t;

    typedef struct {
        logic [5:0]  port;
        logic [31:0] inst;
    } sb_t;

    vec_t       vecs [12];
    sb_t        sb [$];
    int         checks = 0;
    int         failures = 0;
    int         max_cnt = 0;
    logic [5:0] exp_cur;

    localparam logic [6:0] ADD = 7'b0110011;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [1:0] ops, input logic [31:0] inst, input logic [5:0] exp);
        bus.in_valid     = 1'b1;
        bus.in_opcode    = op;
        bus.in_func3     = f3;
        bus.in_funct7    = f7;
        bus.in_valid_ops = ops;
        bus.in_inst_num  = inst;
        bus.in_pc        = inst << 2;
        bus.in_immediate = inst ^ 32'h0000_A5A5;
        bus.in_op1_data  = 32'h1000 + inst;
        bus.in_op2_data  = 32'h2000 + inst;
        bus.in_rd_phy    = inst[7:0];
        bus.in_op1_phy   = 8'h30;
        bus.in_op2_phy   = 8'h31;
        bus.in_ctrl      = 10'h155;
        bus.in_branch    = 1'b0;
        bus.in_taken     = 1'b1;
        bus.in_hit       = 1'b0;
        exp_cur          = exp;
    endtask

    // One clock: account for the handshakes that fire at this edge, then advance
    task automatic step();
        sb_t e;
        if (!reset && !flush && bus.in_valid && bus.in_ready && bus.in_opcode != 7'd0)
            sb.push_back('{exp_cur, bus.in_inst_num});
        if (!reset && !flush && (bus.out_valid & bus.out_ready) != 6'd0) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_dispatch: got port %b inst %0d expected none",
                         bus.out_valid, bus.out_inst_num);
            end else begin
                e = sb.pop_front();
                chk("dispatch_port", {58'd0, bus.out_valid}, {58'd0, e.port});
                chk("dispatch_inst", {32'd0, bus.out_inst_num}, {32'd0, e.inst});
            end
        end
        @(posedge clk);
        #1;
        if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
    endtask

    task automatic enq_go();
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) begin
            acc = bus.in_ready;
            step();
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL enq_timeout: got in_ready 0 expected 1 within 40 cycles");
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic enq(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [1:0] ops, input logic [31:0] inst, input logic [5:0] exp);
        set_in(op, f3, f7, ops, inst, exp);
        enq_go();
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && bus.count != 0; i++) step();
        chk("drain_count", {61'd0, bus.count}, 64'd0);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{ADD,        3'b000, 7'b0000000, 2'b11, 6'b000001};
        vecs[1]  = '{ADD,        3'b000, 7'b0000000, 2'b10, 6'b000010};
        vecs[2]  = '{ADD,        3'b000, 7'b0000001, 2'b11, 6'b000100};
        vecs[3]  = '{ADD,        3'b100, 7'b0000001, 2'b11, 6'b001000};
        vecs[4]  = '{ADD,        3'b110, 7'b0000001, 2'b11, 6'b001000};
        vecs[5]  = '{7'b0000011, 3'b010, 7'b0000000, 2'b11, 6'b010000};
        vecs[6]  = '{7'b1100011, 3'b000, 7'b0000000, 2'b11, 6'b100000};
        vecs[7]  = '{ADD,        3'b001, 7'b0000001, 2'b11, 6'b000001};
        vecs[8]  = '{7'b0100011, 3'b010, 7'b0000000, 2'b00, 6'b010000};
        vecs[9]  = '{7'b1101111, 3'b000, 7'b0000000, 2'b00, 6'b100000};
        vecs[10] = '{7'b1100111, 3'b000, 7'b0000000, 2'b01, 6'b100000};
        vecs[11] = '{7'b0010011, 3'b000, 7'b0000000, 2'b01, 6'b000010};

        reset = 1'b1;
        flush = 1'b0;
        set_in(7'd0, 3'd0, 7'd0, 2'b00, 32'd0, 6'd0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 6'd0;
        bus.cdb_valid = 1'b0;
        bus.cdb_phy   = 8'd0;
        bus.cdb_data  = 32'd0;
        step();
        step();
        reset = 1'b0;
        chk("reset_out_valid", {58'd0, bus.out_valid}, 64'd0);
        chk("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("reset_count", {61'd0, bus.count}, 64'd0);
        chk("reset_out_pc", {32'd0, bus.out_pc}, 64'd0);
        chk("reset_out_inst", {32'd0, bus.out_inst_num}, 64'd0);
        chk("reset_out_ops", {62'd0, bus.out_valid_ops}, 64'd0);

        // Single ADD with both operands ready goes to PASS one cycle after acceptance
        enq(ADD, 3'b000, 7'd0, 2'b11, 32'd1, 6'b000001);
        chk("add_out_valid", {58'd0, bus.out_valid}, 64'h01);
        chk("add_count", {61'd0, bus.count}, 64'd1);
        chk("add_out_pc", {32'd0, bus.out_pc}, 64'd4);
        chk("add_out_op1", {32'd0, bus.out_op1_data}, 64'h1001);
        chk("add_out_ctrl", {54'd0, bus.out_ctrl}, 64'h155);
        bus.out_ready = 6'b000001;
        step();
        chk("add_count_after", {61'd0, bus.count}, 64'd0);

        // Back-to-back class vectors with every port ready: occupancy never exceeds 1
        max_cnt = 0;
        bus.out_ready = 6'h3F;
        for (int i = 0; i < 12; i++)
            enq(vecs[i].opcode, vecs[i].f3, vecs[i].f7, vecs[i].ops, 32'(10 + i), vecs[i].exp_port);
        drain();
        chk("stream_max_count", 64'(max_cnt), 64'd1);

        // Wakeup of a stalled head switches it from ALU to PASS
        bus.out_ready = 6'b111101;
        set_in(ADD, 3'b000, 7'd0, 2'b10, 32'd50, 6'b000001);
        bus.in_op2_phy = 8'h15;
        enq_go();
        chk("wake_pre_valid", {58'd0, bus.out_valid}, 64'h02);
        step();
        chk("wake_stall_valid", {58'd0, bus.out_valid}, 64'h02);
        chk("wake_stall_inst", {32'd0, bus.out_inst_num}, 64'd50);
        bus.cdb_valid = 1'b1;
        bus.cdb_phy   = 8'h15;
        bus.cdb_data  = 32'hDEADBEEF;
        step();
        bus.cdb_valid = 1'b0;
        chk("wake_post_valid", {58'd0, bus.out_valid}, 64'h01);
        chk("wake_op2_data", {32'd0, bus.out_op2_data}, 64'hDEADBEEF);
        chk("wake_ops", {62'd0, bus.out_valid_ops}, 64'd3);
        step();
        chk("wake_count", {61'd0, bus.count}, 64'd0);

        // CDB match in the very cycle of enqueue
        bus.out_ready = 6'd0;
        set_in(ADD, 3'b000, 7'd0, 2'b01, 32'd60, 6'b000001);
        bus.in_op1_phy = 8'h22;
        bus.cdb_valid  = 1'b1;
        bus.cdb_phy    = 8'h22;
        bus.cdb_data   = 32'h12345678;
        enq_go();
        bus.cdb_valid = 1'b0;
        chk("enq_wake_valid", {58'd0, bus.out_valid}, 64'h01);
        chk("enq_wake_op1", {32'd0, bus.out_op1_data}, 64'h12345678);
        bus.out_ready = 6'h3F;
        drain();

        // Fill to DEPTH, hold a fifth, free one slot, then check wrap order
        bus.out_ready = 6'd0;
        for (int i = 1; i <= 4; i++) enq(ADD, 3'b000, 7'd0, 2'b11, 32'(70 + i), 6'b000001);
        chk("full_count", {61'd0, bus.count}, 64'd4);
        chk("full_in_ready", {63'd0, bus.in_ready}, 64'd0);
        set_in(ADD, 3'b000, 7'd0, 2'b11, 32'd75, 6'b000001);
        step();
        step();
        chk("held_count", {61'd0, bus.count}, 64'd4);
        chk("held_in_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("held_head", {32'd0, bus.out_inst_num}, 64'd71);
        bus.out_ready = 6'b000001;
        step();
        bus.out_ready = 6'd0;
        chk("freed_count", {61'd0, bus.count}, 64'd3);
        chk("freed_in_ready", {63'd0, bus.in_ready}, 64'd1);
        step();
        bus.in_valid = 1'b0;
        chk("refill_count", {61'd0, bus.count}, 64'd4);
        bus.out_ready = 6'h3F;
        drain();

        // Flush with a concurrent enqueue attempt
        bus.out_ready = 6'd0;
        for (int i = 0; i < 3; i++) enq(ADD, 3'b000, 7'd0, 2'b11, 32'(80 + i), 6'b000001);
        set_in(ADD, 3'b000, 7'd0, 2'b11, 32'd99, 6'b000001);
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        sb.delete();
        chk("flush_count", {61'd0, bus.count}, 64'd0);
        chk("flush_out_valid", {58'd0, bus.out_valid}, 64'd0);
        chk("flush_in_ready", {63'd0, bus.in_ready}, 64'd1);
        step();
        chk("flush_no_capture", {61'd0, bus.count}, 64'd0);

        // Opcode 0 between two ADDs is consumed without taking a slot
        max_cnt = 0;
        enq(ADD, 3'b000, 7'd0, 2'b11, 32'd90, 6'b000001);
        enq(7'd0, 3'b000, 7'd0, 2'b11, 32'd91, 6'b000001);
        enq(ADD, 3'b000, 7'd0, 2'b11, 32'd92, 6'b000001);
        chk("nop_count", {61'd0, bus.count}, 64'd2);
        bus.out_ready = 6'h3F;
        drain();
        chk("nop_max_count", 64'(max_cnt), 64'd2);

        // Reset during a stall discards the held head
        bus.out_ready = 6'd0;
        enq(ADD, 3'b000, 7'd0, 2'b11, 32'd95, 6'b000001);
        reset = 1'b1;
        step();
        reset = 1'b0;
        sb.delete();
        chk("rst_stall_count", {61'd0, bus.count}, 64'd0);
        chk("rst_stall_valid", {58'd0, bus.out_valid}, 64'd0);
        chk("rst_stall_inst", {32'd0, bus.out_inst_num}, 64'd0);
        bus.out_ready = 6'h3F;
        step();
        step();
        chk("rst_stall_after", {61'd0, bus.count}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rs_dispatch_queue.md
RS_DISPATCH_QUEUE -- requirements
Module: rs_dispatch_queue

Interface
REQ-001 Parameters SHALL be: DEPTH, default 4, queue entries (power of 2, >=2); PHY_W, default 8, physical-register tag width; XLEN, default 32, data/PC/immediate width; PASS_EN, default 1, enables the ready-operand pass path.
REQ-002 Ports (name direction width meaning) SHALL be: clk in 1 clock; reset in 1 synchronous active-high reset.
REQ-003 flush in 1 discard all queued entries.
REQ-004 in_valid in 1 and in_ready out 1 form the enqueue handshake.
REQ-005 in_opcode in 7, in_func3 in 3, in_funct7 in 7 carry the instruction decode fields.
REQ-006 in_pc, in_immediate, in_inst_num, in_op1_data, in_op2_data in XLEN each carry the instruction payload.
REQ-007 in_rd_phy, in_op1_phy, in_op2_phy in PHY_W each carry physical tags; in_valid_ops in 2 holds operand-ready bits ([1]=op1, [0]=op2).
REQ-008 in_ctrl in 10 carries {MemToReg, MemRead, MemWrite, ALUOP[3:0], ALUSrc1, ALUSrc2, Jump}; in_branch in 1; in_taken in 1; in_hit in 1.
REQ-009 cdb_valid in 1, cdb_phy in PHY_W, cdb_data in XLEN form the result-broadcast wakeup.
REQ-010 out_valid out 6 one-hot port-valid {BR,LS,DIV,MUL,ALU,PASS}; out_ready in 6 per-port ready.
REQ-011 out_* out SHALL mirror every in_* payload field at the same widths, plus out_valid_ops out 2.
REQ-012 count out $clog2(DEPTH)+1 reports occupancy.

Function
REQ-013 Enqueue SHALL occur on a rising edge with in_valid && in_ready && !flush; in_ready SHALL equal !full, with no combinational path from out_ready.
REQ-014 An instruction with in_opcode==0 SHALL be accepted and dropped without occupying an entry.
REQ-015 Class SHALL be fixed at enqueue: opcode 1101111/1100111/1100011 -> BR; 0000011/0100011 -> LS; 0110011 with funct7 0000001 and func3 000 -> MUL; same with func3 100 or 110 -> DIV; everything else -> ALU-class.
REQ-016 Every cycle, each valid entry whose op1 or op2 tag equals cdb_phy while cdb_valid is high SHALL set that ready bit and capture cdb_data into the corresponding data field.
REQ-017 The enqueueing instruction SHALL receive the same CDB match in the cycle it enters.
REQ-018 Only the head entry SHALL be presented; dispatch SHALL be strictly in order.
REQ-019 An ALU-class head SHALL route to PASS when PASS_EN==1 and both ready bits are 1 (post-wakeup register value), and to ALU otherwise.
REQ-020 out_valid SHALL be one-hot while non-empty and zero while empty; it SHALL depend only on registered state.
REQ-021 Dequeue SHALL occur when out_valid & out_ready is nonzero; a not-ready target SHALL stall the head while payload stays stable.
REQ-022 Simultaneous enqueue and dequeue SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-023 Minimum latency SHALL be 1 cycle: an entry is visible on out_* the cycle after acceptance.
REQ-024 flush SHALL empty the queue at the edge, override a simultaneous enqueue or dequeue, and drive out_valid=0 the next cycle.

Reset
REQ-025 Synchronous reset SHALL clear pointers, count, and all entry valid bits, and drive out_valid=0, in_ready=1, count=0, and all out_* payload to 0.
REQ-026 Reset SHALL take priority over flush, enqueue, and dequeue; reset mid-stall SHALL discard the held head.

Structure
REQ-027 Class encodings, one-hot port indices, and opcode constants SHALL live in a shared dispatch package.
REQ-028 The classifier SHALL be a combinational sub-module, dispatch_classify (opcode, func3, funct7 -> class).

Verification
REQ-029 Scenario: reset, then enqueue ADD (0110011, valid_ops=11, PASS_EN=1) -> next cycle out_valid=000001; with out_ready[0]=1, count returns to 0.
REQ-030 Scenario: MUL, DIV(func3=100), REM(110), LW, BEQ each enqueued with all out_ready=1 -> out_valid sequence 000100, 001000, 001000, 010000, 100000, in order.
REQ-031 Scenario: ADD with valid_ops=10 and op2 tag 0x15 held with ALU not ready; CDB 0x15/0xDEADBEEF -> head switches to PASS, out_op2_data=0xDEADBEEF.
REQ-032 Scenario: DEPTH=4; five enqueues with out_ready=0 -> in_ready=0 after the fourth, the fifth is held, count=4; one dequeue -> the fifth is accepted, wrap correct.
REQ-033 Scenario: three entries queued, flush with in_valid=1 -> count=0, out_valid=0, the in_valid instruction is not captured.
REQ-034 Scenario: opcode 0 enqueued between two ADDs -> only the two ADDs are dispatched, count never exceeds 2.
